ysyx_23060303_ifu: RTL and testbench
====================================

YSYX_23060303_IFU -- requirements
Module: ysyx_23060303_IFU

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 SHALL have port redirect_valid  input  1  control-flow change request from execute stage.
REQ-005 SHALL have port redirect_pc  input  32  target PC for redirect.
REQ-006 SHALL have ports imem_req_valid  output  1, imem_req_ready  input  1, and imem_req_addr  output  32, forming the instruction-memory request handshake.
REQ-007 SHALL have ports imem_rsp_valid  input  1 and imem_rsp_data  input  32, carrying the instruction-memory response, always accepted.
REQ-008 SHALL have ports inst_valid  output  1 and inst_ready  input  1, forming the handshake to the decode stage.
REQ-009 SHALL have ports inst  output  32 and inst_pc  output  32, carrying the fetched instruction word and its address to decode.
REQ-010 SHALL have port misalign_err  output  1, present only when the Configuration macro is defined.

Function
REQ-011 SHALL implement states FETCH, WAIT, HOLD (plus HALT under the Configuration macro).
REQ-012 SHALL, in FETCH: drive imem_req_valid=1, imem_req_addr=pc; on imem_req_ready=1, go to WAIT.
REQ-013 SHALL keep at most one request outstanding; imem_req_valid=0 in WAIT, HOLD and HALT.
REQ-014 SHALL keep imem_req_addr stable while imem_req_valid=1 and not accepted, unless a redirect occurs.
REQ-015 SHALL, in WAIT on imem_rsp_valid=1 with no drop pending: register inst<=imem_rsp_data and inst_pc<=pc, go to HOLD; inst_valid=1 from the next cycle (1-cycle registered latency).
REQ-016 SHALL, in HOLD: hold inst_valid=1 with inst and inst_pc stable until inst_ready=1; on handshake, pc<=pc+4, go to FETCH, inst_valid=0 next cycle.
REQ-017 SHALL compute pc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-018 SHALL give redirect_valid priority over all other events in every state: pc<=redirect_pc.
REQ-019 SHALL, on redirect in FETCH without request acceptance, go to FETCH (new address next cycle); with acceptance the same cycle, go to WAIT with drop flag set.
REQ-020 SHALL, on redirect in WAIT (including same cycle as imem_rsp_valid), set the drop flag or discard that response; a dropped response SHALL never reach inst, and the state then returns to FETCH.
REQ-021 SHALL, on redirect in HOLD, deassert inst_valid next cycle and go to FETCH; a simultaneous inst_ready handshake counts as consumed, and pc takes redirect_pc, not pc+4.
REQ-022 SHALL clear the drop flag when the dropped response arrives.

Reset
REQ-023 SHALL, with rst_n=0 at a rising edge: pc<=RESET_PC, state<=FETCH, drop flag<=0, inst_valid<=0, inst<=0, inst_pc<=0, misalign_err<=0.
REQ-024 SHALL drive imem_req_valid=0 during reset cycles; the first request is issued on the first cycle with rst_n=1.
REQ-025 SHALL treat reset mid-transaction as abort; a late response after reset is ignored (drop flag set if reset occurred in WAIT).

Configuration
REQ-026 SHALL honour macro YSYX_23060303_IFU_MISALIGN_CHK_EN.
REQ-027 SHALL, with the macro defined and redirect_pc[1:0]!=0: set misalign_err=1 (sticky until reset), enter HALT, and issue no further requests or inst_valid.
REQ-028 SHALL, without the macro, force pc[1:0]=2'b00 on redirect and omit the misalign_err port.

Verification
REQ-029 SHALL test reset release with req_ready=1 and 1-cycle response memory: addresses 0x8000_0000, 0x8000_0004, 0x8000_0008 in order; inst_pc matches each.
REQ-030 SHALL test inst_ready held 0 for 5 cycles: inst and inst_pc stable, no new request issued.
REQ-031 SHALL test redirect to 0x8000_0100 in WAIT with response 3 cycles later: response discarded, next request address 0x8000_0100.
REQ-032 SHALL test redirect to 0x8000_0200 in HOLD with inst_ready=1 in the same cycle: next request address 0x8000_0200, not pc+4.
REQ-033 SHALL test pc=0xFFFF_FFFC consumed: next request address 0x0000_0000.
REQ-034 SHALL test, with the macro defined, redirect to 0x8000_0002: misalign_err=1, imem_req_valid stays 0 until reset.

Source files
------------

// File: rtl/ysyx_23060303_ifu.sv
// Instruction fetch unit: one outstanding imem request, registered hand-off to decode, redirect support.
// Optional misaligned-redirect trap (misalign_err port, HALT state) enabled by YSYX_23060303_IFU_MISALIGN_CHK_EN.
module ysyx_23060303_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef YSYX_23060303_IFU_MISALIGN_CHK_EN
    ,
    output logic        misalign_err
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
`ifdef YSYX_23060303_IFU_MISALIGN_CHK_EN
        ,
        S_HALT  = 2'd3
`endif
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        drop_q;
    logic        inst_valid_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic [31:0] redirect_tgt_d;
    logic [31:0] pc_inc_d;
    logic        redirect_bad_d;

`ifdef YSYX_23060303_IFU_MISALIGN_CHK_EN
    logic misalign_q;
    assign redirect_tgt_d = redirect_pc;
    assign redirect_bad_d = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign misalign_err   = misalign_q;
`else
    logic unused_redirect_low;
    assign unused_redirect_low = ^redirect_pc[1:0];
    assign redirect_tgt_d = {redirect_pc[31:2], 2'b00};
    assign redirect_bad_d = 1'b0;
`endif

    assign pc_inc_d       = pc_q + 32'd4;
    assign imem_req_valid = rst_n && (state_q == S_FETCH);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            // A request abandoned by reset may still answer later; remember to discard it.
            drop_q       <= (state_q == S_WAIT) || (drop_q && !imem_rsp_valid);
            inst_valid_q <= 1'b0;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
`ifdef YSYX_23060303_IFU_MISALIGN_CHK_EN
            misalign_q   <= 1'b0;
`endif
        end else if (redirect_bad_d) begin
`ifdef YSYX_23060303_IFU_MISALIGN_CHK_EN
            misalign_q   <= 1'b1;
            state_q      <= S_HALT;
`endif
            inst_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (drop_q && imem_rsp_valid) begin
                        drop_q <= 1'b0;
                    end
                    if (redirect_valid) begin
                        pc_q <= redirect_tgt_d;
                        if (imem_req_ready) begin
                            state_q <= S_WAIT;
                            drop_q  <= 1'b1;
                        end
                    end else if (imem_req_ready) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_tgt_d;
                        if (imem_rsp_valid) begin
                            drop_q  <= 1'b0;
                            state_q <= S_FETCH;
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= S_FETCH;
                        end else begin
                            inst_q       <= imem_rsp_data;
                            inst_pc_q    <= pc_q;
                            inst_valid_q <= 1'b1;
                            state_q      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        pc_q         <= redirect_tgt_d;
                        inst_valid_q <= 1'b0;
                        state_q      <= S_FETCH;
                    end else if (inst_ready) begin
                        pc_q         <= pc_inc_d;
                        inst_valid_q <= 1'b0;
                        state_q      <= S_FETCH;
                    end
                end
                default: begin
                    inst_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060303_ifu.sv
// Scoreboard bench for ysyx_23060303_ifu: queued expected request addresses and delivered instructions.
module tb_ysyx_23060303_ifu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef YSYX_23060303_IFU_MISALIGN_CHK_EN
    logic        misalign_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] req_q[$];
    logic [31:0] inst_q[$];
    int          rsp_delay = 1;
    int          rsp_cnt = 0;
    logic [31:0] rsp_addr = 32'd0;
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    ysyx_23060303_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
`ifdef YSYX_23060303_IFU_MISALIGN_CHK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5A5A_1234) + 32'h0000_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Memory model plus scoreboard pops, all sampled on the falling edge.
    always @(negedge clk) begin
        if (inst_valid && inst_ready) begin
            check_eq("inst_pending", 32'(inst_q.size() != 0), 32'd1);
            if (inst_q.size() != 0) begin
                mon_exp = inst_q.pop_front();
                check_eq("inst_pc", inst_pc, mon_exp);
                check_eq("inst", inst, mem_word(mon_exp));
                $display("inst  pc=%08h data=%08h", inst_pc, inst);
            end
        end
        imem_rsp_valid = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(rsp_addr);
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            check_eq("req_pending", 32'(req_q.size() != 0), 32'd1);
            if (req_q.size() != 0) begin
                mon_exp = req_q.pop_front();
                check_eq("req_addr", imem_req_addr, mon_exp);
            end
            $display("req   addr=%08h", imem_req_addr);
            rsp_cnt  = rsp_delay;
            rsp_addr = imem_req_addr;
        end
    end

    task automatic wait_valid(input string tag, input int bound);
        int k = 0;
        while (!inst_valid && k < bound) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(inst_valid), 32'd1);
    endtask

    task automatic wait_inst_q(input string tag, input int n, input int bound);
        int k = 0;
        while (inst_q.size() > n && k < bound) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq(tag, 32'(inst_q.size()), 32'(n));
    endtask

    task automatic push_fetch(input logic [31:0] a);
        req_q.push_back(a);
        inst_q.push_back(a);
    endtask

    task automatic redirect_in_hold(input logic [31:0] tgt, input logic keep_ready);
        @(posedge clk);
        #1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        inst_ready     = keep_ready;
    endtask

    initial begin
        int k;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst_inst", inst, 32'd0);
        check_eq("rst_inst_pc", inst_pc, 32'd0);

        // Sequential fetch from reset, park the fourth instruction in HOLD
        push_fetch(32'h8000_0000);
        push_fetch(32'h8000_0004);
        push_fetch(32'h8000_0008);
        push_fetch(32'h8000_000C);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_inst_q("seq_drain", 1, 40);
        inst_ready = 1'b0;

        // Decode stall: output stable, no new request
        wait_valid("stall_valid", 20);
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_inst_pc", inst_pc, 32'h8000_000C);
            check_eq("stall_inst", inst, mem_word(32'h8000_000C));
            check_eq("stall_req_valid", 32'(imem_req_valid), 32'd0);
            @(negedge clk);
        end

        // Redirect while waiting for a slow response: response must be discarded
        req_q.push_back(32'h8000_0010);
        push_fetch(32'h8000_0100);
        rsp_delay = 3;
        @(posedge clk);
        #1 inst_ready = 1'b1;
        k = 0;
        while (!(imem_req_valid && imem_req_ready) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_eq("wait_accept", 32'(imem_req_valid), 32'd1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        inst_ready     = 1'b0;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        wait_valid("drop_valid", 40);
        check_eq("drop_inst_pc", inst_pc, 32'h8000_0100);

        // Redirect in HOLD together with consume: target wins over pc+4
        push_fetch(32'h8000_0200);
        rsp_delay = 1;
        redirect_in_hold(32'h8000_0200, 1'b0);
        wait_valid("hold_redir_valid", 30);
        check_eq("hold_redir_pc", inst_pc, 32'h8000_0200);

        // pc+4 wraps past the top of the address space
        push_fetch(32'hFFFF_FFFC);
        push_fetch(32'h0000_0000);
        redirect_in_hold(32'hFFFF_FFFC, 1'b1);
        wait_inst_q("wrap_drain", 1, 40);
        inst_ready = 1'b0;
        wait_valid("wrap_valid", 30);
        check_eq("wrap_pc", inst_pc, 32'h0000_0000);

`ifdef YSYX_23060303_IFU_MISALIGN_CHK_EN
        // Misaligned redirect halts fetch until reset
        redirect_in_hold(32'h8000_0002, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("halt_misalign", 32'(misalign_err), 32'd1);
            check_eq("halt_req_valid", 32'(imem_req_valid), 32'd0);
            check_eq("halt_inst_valid", 32'(inst_valid), 32'd0);
        end
`else
        // Low redirect bits are forced to zero
        push_fetch(32'h8000_0300);
        redirect_in_hold(32'h8000_0302, 1'b0);
        wait_valid("mask_valid", 30);
        check_eq("mask_pc", inst_pc, 32'h8000_0300);
`endif

        // Reset mid-run, then restart from RESET_PC
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst2_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst2_inst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst2_inst", inst, 32'd0);
        check_eq("rst2_inst_pc", inst_pc, 32'd0);
`ifdef YSYX_23060303_IFU_MISALIGN_CHK_EN
        check_eq("rst2_misalign", 32'(misalign_err), 32'd0);
`endif
        req_q.delete();
        inst_q.delete();
        push_fetch(32'h8000_0000);
        req_q.push_back(32'h8000_0004);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        wait_inst_q("restart_drain", 0, 40);
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;

        // Unaccepted request keeps its address
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall_req_valid_hi", 32'(imem_req_valid), 32'd1);
            check_eq("stall_req_addr", imem_req_addr, 32'h8000_0004);
        end
        check_eq("end_inst_q", 32'(inst_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
